sauria_psum_sramc_writer: RTL

// Output-side counterpart of the IFmap feeder and weight fetcher. The feeders read SRAM A/B into the systolic array; this block drains the array instead.
// It accepts Y-row partial-sum beats shifted out of the array and packs them into SRAMC_W-bit words.

---
 rtl/sauria_psum_sramc_writer_if.sv | 48 ++++
 rtl/sauria_psum_sramc_writer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sauria_psum_sramc_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : sauria_psum_sramc_writer_if
// Purpose  : Bundles the psum beat handshake (array shift-chain side) and the
//            SRAM C write port of the partial-sum writer.
// Signals  : i_psum_valid / o_psum_ready / i_psum_data  - psum beat stream
//            o_sramc_wren / o_sramc_addr / o_sramc_wdata /
//            o_sramc_wmask                              - SRAM C write port
// Modports : slave  - the writer (consumes beats, drives SRAM C)
//            master - the environment (produces beats, observes SRAM C)
// Revision : 1.0 - initial release
// ============================================================================
interface sauria_psum_sramc_writer_if #(
    parameter int Y       = 8,
    parameter int OC_W    = 32,
    parameter int SRAMC_W = 128,
    parameter int ADRC_W  = 11,
    parameter int SRAMC_N = SRAMC_W / OC_W
);
    logic                  i_psum_valid;
    logic                  o_psum_ready;
    logic [Y*OC_W-1:0]     i_psum_data;
    logic                  o_sramc_wren;
    logic [ADRC_W-1:0]     o_sramc_addr;
    logic [SRAMC_W-1:0]    o_sramc_wdata;
    logic [SRAMC_N-1:0]    o_sramc_wmask;

    modport slave (
        input  i_psum_valid,
        input  i_psum_data,
        output o_psum_ready,
        output o_sramc_wren,
        output o_sramc_addr,
        output o_sramc_wdata,
        output o_sramc_wmask
    );

    modport master (
        output i_psum_valid,
        output i_psum_data,
        input  o_psum_ready,
        input  o_sramc_wren,
        input  o_sramc_addr,
        input  o_sramc_wdata,
        input  o_sramc_wmask
    );
endinterface
`default_nettype wire

// File: rtl/sauria_psum_sramc_writer.sv
`default_nettype none
// ============================================================================
// Module   : sauria_psum_sramc_writer
// Purpose  : Drains Y-row partial-sum beats from the systolic array output
//            chain, packs them into SRAMC_W-bit words (WPB = Y/SRAMC_N words
//            per beat) and writes them to SRAM C at consecutive, wrapping
//            addresses starting from a programmed base, with per-element
//            write masks derived from the number of valid rows.
// Ports    : i_clk, i_rst (sync, active-high)
//            i_start, i_base_addr, i_n_beats, i_rows_valid - tile config
//            bus (slave)  - psum beat handshake + SRAM C write port
//            o_busy       - high while draining beats (RUN)
//            o_done       - one-cycle pulse after the last word is written
// Revision : 1.0 - initial release
// ============================================================================
module sauria_psum_sramc_writer #(
    parameter int Y       = 8,
    parameter int OC_W    = 32,
    parameter int SRAMC_W = 128,
    parameter int ADRC_W  = 11,
    parameter int NBEAT_W = 16
) (
    input  wire logic                 i_clk,
    input  wire logic                 i_rst,
    input  wire logic                 i_start,
    input  wire logic [ADRC_W-1:0]    i_base_addr,
    input  wire logic [NBEAT_W-1:0]   i_n_beats,
    input  wire logic [$clog2(Y):0]   i_rows_valid,
    sauria_psum_sramc_writer_if.slave bus,
    output logic                      o_busy,
    output logic                      o_done
);
    localparam int SRAMC_N = SRAMC_W / OC_W;
    localparam int WPB     = Y / SRAMC_N;
    localparam int KW      = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int RV_W    = $clog2(Y) + 1;

    localparam logic [KW-1:0] c_LAST_K = KW'(WPB - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    logic [1:0]                      r_state;
    logic [NBEAT_W-1:0]              r_beats_left;
    logic [RV_W-1:0]                 r_rows_valid;
    logic [ADRC_W-1:0]               r_next_addr;
    logic [WPB-1:0][SRAMC_W-1:0]     r_buf;
    logic [KW-1:0]                   r_k;        // index of the word on the write port
    logic                            r_wren;
    logic [ADRC_W-1:0]               r_addr;
    logic [SRAMC_W-1:0]              r_wdata;
    logic [SRAMC_N-1:0]              r_wmask;
    logic                            r_done;

    logic                            w_more;
    logic                            w_ready;
    logic                            w_accept;
    logic                            w_issue;
    logic [KW-1:0]                   w_next_k;
    logic [SRAMC_W-1:0]              w_next_wdata;
    logic [SRAMC_N-1:0]              w_next_wmask;
    logic [WPB-1:0][SRAMC_W-1:0]     w_in_words;

    assign w_in_words = bus.i_psum_data;

    // Buffered beat still owes words after the one currently on the port.
    assign w_more   = r_wren && (r_k != c_LAST_K);
    // A new beat may enter when the port is idle or showing the final word of
    // the previous beat, so word 0 of the next beat follows with no bubble.
    assign w_ready  = (r_state == c_RUN) && (r_beats_left != '0) && !w_more;
    assign w_accept = w_ready && bus.i_psum_valid;
    assign w_issue  = w_more || w_accept;

    // Next word: continue from the buffer, otherwise word 0 straight from the
    // incoming beat (the beat is captured into the buffer on the same edge).
    always_comb begin
        w_next_k     = '0;
        w_next_wdata = w_in_words[0];
        w_next_wmask = '0;
        if (w_more) begin
            w_next_k     = r_k + KW'(1);
            w_next_wdata = r_buf[w_next_k];
        end
        for (int j = 0; j < SRAMC_N; j++) begin
            w_next_wmask[j] = ((int'(w_next_k) * SRAMC_N + j) < int'(r_rows_valid));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= c_IDLE;
            r_beats_left <= '0;
            r_rows_valid <= '0;
            r_next_addr  <= '0;
            r_buf        <= '0;
            r_k          <= '0;
            r_wren       <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // addr/wdata/wmask hold their last values while wren is low.
            if (w_issue) begin
                r_wren      <= 1'b1;
                r_k         <= w_next_k;
                r_addr      <= r_next_addr;
                r_next_addr <= r_next_addr + ADRC_W'(1);   // wraps mod 2**ADRC_W
                r_wdata     <= w_next_wdata;
                r_wmask     <= w_next_wmask;
            end else begin
                r_wren <= 1'b0;
            end

            if (w_accept) begin
                r_buf        <= w_in_words;
                r_beats_left <= r_beats_left - NBEAT_W'(1);
            end

            case (r_state)
                c_IDLE: begin
                    if (i_start) begin
                        if (i_n_beats == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state      <= c_RUN;
                            r_next_addr  <= i_base_addr;
                            r_beats_left <= i_n_beats;
                            r_rows_valid <= i_rows_valid;
                        end
                    end
                end
                c_RUN: begin
                    if (w_accept && (r_beats_left == NBEAT_W'(1))) begin
                        r_state <= c_FLUSH;
                    end
                end
                c_FLUSH: begin
                    // The last word is on the port now; done follows next cycle.
                    if (!w_more) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.o_psum_ready  = w_ready;
    assign bus.o_sramc_wren  = r_wren;
    assign bus.o_sramc_addr  = r_addr;
    assign bus.o_sramc_wdata = r_wdata;
    assign bus.o_sramc_wmask = r_wmask;
    assign o_busy            = (r_state == c_RUN);
    assign o_done            = r_done;

endmodule
`default_nettype wire
